// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// Optional macro MEM_ARB_CLEAR_EN: zero-fill the whole memory after reset before granting.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ-1:0]        i_req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic [1:0]                o_mem_op,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic [DATA_W-1:0]         o_mem_data,
  input  logic [DATA_W-1:0]         i_mem_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;

  typedef enum logic {S_RUN, S_CLEAR} state_t;

`ifdef MEM_ARB_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_RUN;
`endif

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [1:0]          mem_op_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                tag1_vld_q, tag2_vld_q;
  logic [IDX_W-1:0]    tag1_id_q, tag2_id_q;

  logic                gnt_vld;
  logic [IDX_W-1:0]    gnt_idx;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Search starts at ptr_q and wraps; the first valid requester wins.
  always_comb begin
    int j;
    j           = 0;
    gnt_vld     = 1'b0;
    gnt_idx     = '0;
    sel_write   = 1'b0;
    sel_addr    = '0;
    sel_data    = '0;
    o_req_ready = '0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        j = (int'(ptr_q) + i) % NUM_REQ;
        if (!gnt_vld && i_req_valid[j]) begin
          gnt_vld        = 1'b1;
          gnt_idx        = IDX_W'(j);
          sel_write      = i_req_write[j];
          sel_addr       = i_req_addr[j*ADDR_W +: ADDR_W];
          sel_data       = i_req_data[j*DATA_W +: DATA_W];
          o_req_ready[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RST_STATE;
      ptr_q      <= '0;
      mem_op_q   <= OP_NONE;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      clr_cnt_q  <= '0;
      tag1_vld_q <= 1'b0;
      tag1_id_q  <= '0;
      tag2_vld_q <= 1'b0;
      tag2_id_q  <= '0;
    end else begin
      // The tag follows the op into the memory's read edge.
      tag2_vld_q <= tag1_vld_q;
      tag2_id_q  <= tag1_id_q;
      case (state_q)
        S_CLEAR: begin
          mem_op_q   <= OP_WR;
          mem_addr_q <= clr_cnt_q;
          mem_data_q <= '0;
          tag1_vld_q <= 1'b0;
          clr_cnt_q  <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == '1) state_q <= S_RUN;
        end
        default: begin
          tag1_vld_q <= 1'b0;
          if (gnt_vld) begin
            mem_op_q   <= sel_write ? OP_WR : OP_RD;
            mem_addr_q <= sel_addr;
            mem_data_q <= sel_data;
            tag1_vld_q <= ~sel_write;
            tag1_id_q  <= gnt_idx;
            ptr_q      <= ptr_d;
          end else begin
            mem_op_q <= OP_NONE;
          end
        end
      endcase
    end
  end

  assign o_mem_op    = mem_op_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_rsp_valid = tag2_vld_q ? (NUM_REQ'(1) << tag2_id_q) : '0;
  assign o_rsp_data  = i_mem_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory plus a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 64;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    o_req_ready, o_rsp_valid;
  logic [DW-1:0]   o_rsp_data, o_mem_data, i_mem_data;
  logic [1:0]      o_mem_op;
  logic [AW-1:0]   o_mem_addr;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(req_valid), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_mem_op(o_mem_op), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_data(i_mem_data)
  );

  // Memory port: samples op at the edge, read data appears after that edge.
  logic [DW-1:0] mem [0:8191];
  logic [DW-1:0] mem_q;
  always @(posedge i_clk) begin
    if (o_mem_op == 2'd2) mem[o_mem_addr] <= o_mem_data;
    else if (o_mem_op == 2'd1) mem_q <= mem[o_mem_addr];
  end
  assign i_mem_data = mem_q;

  // Reference model: memory contents applied in acceptance order.
  logic [DW-1:0] ref_mem [0:8191];
  int            ptr_m;
  logic [1:0]    exp_op;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  bit            t1_v, t2_v;
  int            t1_k, t2_k;
  logic [DW-1:0] t1_d, t2_d;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr_m = 0; exp_op = 2'd0; exp_addr = '0; exp_data = '0;
    t1_v = 1'b0; t2_v = 1'b0; t1_k = 0; t2_k = 0; t1_d = '0; t2_d = '0;
  endtask

  task automatic clear_req();
    req_valid = '0; req_write = '0; req_addr = '0; req_data = '0;
  endtask

  task automatic set_req(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    int w, j;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = -1;
    for (int i = 0; i < N; i++) begin
      j = (ptr_m + i) % N;
      if (w < 0 && req_valid[j]) w = j;
    end
    #1;
    check("ready", 64'(o_req_ready), (w >= 0) ? (64'd1 << w) : 64'd0);
    check("mem_op", 64'(o_mem_op), 64'(exp_op));
    check("mem_addr", 64'(o_mem_addr), 64'(exp_addr));
    check("mem_data", o_mem_data, exp_data);
    check("rsp_valid", 64'(o_rsp_valid), t2_v ? (64'd1 << t2_k) : 64'd0);
    if (t2_v) check("rsp_data", o_rsp_data, t2_d);
    @(posedge i_clk);
    t2_v = t1_v; t2_k = t1_k; t2_d = t1_d;
    t1_v = 1'b0;
    if (w >= 0) begin
      a = req_addr[w*AW +: AW];
      d = req_data[w*DW +: DW];
      exp_op = req_write[w] ? 2'd2 : 2'd1;
      exp_addr = a;
      exp_data = d;
      if (req_write[w]) ref_mem[a] = d;
      else begin t1_v = 1'b1; t1_k = w; t1_d = ref_mem[a]; end
      ptr_m = (w + 1) % N;
    end else begin
      exp_op = 2'd0;
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    clear_req();
    for (int i = 0; i < n; i++) cycle();
  endtask

`ifdef MEM_ARB_CLEAR_EN
  task automatic run_clear();
    req_valid = '1;
    for (int c = 0; c < 8192; c++) begin
      #1;
      check("clear_ready", 64'(o_req_ready), 64'd0);
      @(posedge i_clk);
      @(negedge i_clk);
    end
    for (int a = 0; a < 8192; a++) ref_mem[a] = '0;
    exp_op = 2'd2; exp_addr = '1; exp_data = '0;
    t1_v = 1'b0; t2_v = 1'b0;
    clear_req();
  endtask
`endif

  initial begin
    i_rst_n = 1'b0;
    clear_req();
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    check("rst_op", 64'(o_mem_op), 64'd0);
    check("rst_addr", 64'(o_mem_addr), 64'd0);
    check("rst_data", o_mem_data, 64'd0);
    check("rst_rsp", 64'(o_rsp_valid), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
`ifdef MEM_ARB_CLEAR_EN
    run_clear();
    set_req(0, 1'b0, 13'h1FFF, '0);
    cycle();
    idle(3);
`endif

    // Single requester write then read back.
    clear_req(); set_req(1, 1'b1, 13'h010, 64'hDEAD_BEEF); cycle();
    clear_req(); set_req(1, 1'b0, 13'h010, 64'd0); cycle();
    idle(3);

    // Idle keeps the pointer; the next 4-way contest is won by the requester after the last grant.
    clear_req(); set_req(1, 1'b0, 13'h010, 64'd0); cycle();
    idle(4);
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), 64'd0);
    cycle();
    idle(3);

    // Fill addresses 0..15 with known data.
    for (int a = 0; a < 16; a++) begin
      clear_req();
      set_req(a % N, 1'b1, AW'(a), {$urandom, $urandom});
      cycle();
    end
    idle(2);

    // All four streaming reads of address k: grants rotate and responses follow, no gaps.
    clear_req();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), 64'd0);
    for (int i = 0; i < 12; i++) cycle();
    idle(3);

    // Write followed immediately by a read of the same address from another requester.
    clear_req(); set_req(0, 1'b1, 13'h005, 64'h1234); cycle();
    clear_req(); set_req(2, 1'b0, 13'h005, 64'd0); cycle();
    idle(3);

    // Randomized traffic over the pre-filled addresses.
    for (int i = 0; i < 300; i++) begin
      clear_req();
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 1)
          set_req(k, bit'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), {$urandom, $urandom});
      end
      cycle();
    end
    idle(3);

    // Reset with two reads in flight.
    clear_req();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), 64'd0);
    cycle();
    cycle();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_op", 64'(o_mem_op), 64'd0);
    check("midrst_addr", 64'(o_mem_addr), 64'd0);
    check("midrst_data", o_mem_data, 64'd0);
    check("midrst_rsp", 64'(o_rsp_valid), 64'd0);
    clear_req();
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
`ifdef MEM_ARB_CLEAR_EN
    run_clear();
`endif
    idle(3);
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), 64'd0);
    for (int i = 0; i < 6; i++) cycle();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
